// File: rtl/button_debounce_if.sv
// Button bundle between the raw pins and the display controller.
// There is no valid/ready handshake. btn_in is sampled on every clk edge.
// Each output is a registered per-cycle flag, and the consumer samples it every cycle.
interface button_debounce_if #(
    parameter int N = 3
);
    logic [N-1:0] btn_in;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_press;
    logic [N-1:0] btn_release;
    logic [N-1:0] btn_long;

    // Driver of the raw pins / consumer of the conditioned outputs
    modport master (
        output btn_in,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  btn_long
    );

    // The debouncer itself
    modport slave (
        input  btn_in,
        output btn_level,
        output btn_press,
        output btn_release,
        output btn_long
    );
endinterface

// File: rtl/button_debounce.sv
// Multi-channel push-button conditioner.
// Each channel runs a two-flop synchroniser and then a stable-count debounce filter.
// From the clean level it derives press, release and long-press pulses, all registered.
module button_debounce #(
    parameter int N             = 3,
    parameter int STABLE_CYCLES = 4,
    parameter int LONG_CYCLES   = 16
) (
    input  logic            clk,
    input  logic            rst,
    button_debounce_if.slave bus
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int HW = $clog2(LONG_CYCLES + 1);

    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES);
    localparam logic [HW-1:0] HOLD_PRE = HW'(LONG_CYCLES - 1);

    logic [N-1:0]  sync1;
    logic [N-1:0]  sync2;
    logic [N-1:0]  level;
    logic [N-1:0]  press_q;
    logic [N-1:0]  rel_q;
    logic [N-1:0]  long_q;
    logic [N-1:0]  fire;
    logic [CW-1:0] cnt  [N];
    logic [HW-1:0] hold [N];

    // Flag the edge on which a channel's debounced level flips (press or release)
    always_comb begin
        fire = '0;
        for (int i = 0; i < N; i++) begin
            fire[i] = (sync2[i] != level[i]) && (cnt[i] == CNT_LAST);
        end
    end

    // Synchronise the raw pins and run the stable-count filter that owns btn_level and press/release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1   <= '0;
            sync2   <= '0;
            level   <= '0;
            press_q <= '0;
            rel_q   <= '0;
            for (int i = 0; i < N; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1   <= bus.btn_in;
            sync2   <= sync1;
            press_q <= '0;
            rel_q   <= '0;
            for (int i = 0; i < N; i++) begin
                if (sync2[i] == level[i]) begin
                    // A glitch back to the current level restarts the count
                    cnt[i] <= '0;
                end else if (fire[i]) begin
                    level[i]   <= sync2[i];
                    cnt[i]     <= '0;
                    press_q[i] <= sync2[i];
                    rel_q[i]   <= ~sync2[i];
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Time how long the level stays high and emit one long-press pulse per press
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            long_q <= '0;
            for (int i = 0; i < N; i++) begin
                hold[i] <= '0;
            end
        end else begin
            long_q <= '0;
            for (int i = 0; i < N; i++) begin
                // fire while high is a release edge: it clears hold and suppresses long
                if (!level[i] || fire[i]) begin
                    hold[i] <= '0;
                end else if (hold[i] != HOLD_MAX) begin
                    hold[i]   <= hold[i] + 1'b1;
                    long_q[i] <= (hold[i] == HOLD_PRE);
                end
            end
        end
    end

    assign bus.btn_level   = level;
    assign bus.btn_press   = press_q;
    assign bus.btn_release = rel_q;
    assign bus.btn_long    = long_q;
endmodule
